// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI master: FSM state encoding and idle pin levels.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_NEXT  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } spi_state_t;

  // Mode 0: SCK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_SSEL_IDLE = 1'b1;

endpackage

// File: rtl/spi_tick_gen.sv
// SCK half-period divider: counts 0..CLK_DIV-1 while enabled, pulses tick on the last count.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/spi_master_tx.sv
// Mode-0 SPI master with streaming byte input, full-duplex MISO capture and
// frame control (SSEL held low across words until a word flagged last).
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SSEL
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  spi_state_t        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic [DATA_W-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic [BW-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic              r_last, w_last_nxt;
  logic              r_sck, w_sck_nxt;
  logic              r_mosi, w_mosi_nxt;
  logic              r_ssel, w_ssel_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              w_accept, w_div_en, w_tick;

  assign tx_ready = (r_state == ST_IDLE) || (r_state == ST_NEXT);
  assign busy     = (r_state != ST_IDLE);
  assign w_accept = tx_valid && tx_ready;
  // Divider only runs in timed states; it restarts from zero on every accept.
  assign w_div_en = !tx_ready;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (clk),
    .i_res_n (res_n),
    .i_clr   (!w_div_en),
    .i_en    (w_div_en),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_data_nxt  = r_rx_data;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_last_nxt     = r_last;
    w_sck_nxt      = r_sck;
    w_mosi_nxt     = r_mosi;
    w_ssel_nxt     = r_ssel;
    w_rx_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_NEXT: if (w_accept) begin
        w_shreg_nxt   = tx_data;
        w_last_nxt    = tx_last;
        w_ssel_nxt    = 1'b0;
        w_mosi_nxt    = tx_data[DATA_W-1];
        w_bit_cnt_nxt = '0;
        w_state_nxt   = (r_state == ST_IDLE) ? ST_SETUP : ST_LOW;
      end
      ST_SETUP, ST_LOW: if (w_tick) begin
        w_sck_nxt   = 1'b1;
        w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], MISO};
        w_state_nxt = ST_HIGH;
      end
      ST_HIGH: if (w_tick) begin
        w_sck_nxt = 1'b0;
        if (r_bit_cnt == BW'(DATA_W - 1)) begin
          w_rx_data_nxt  = r_rx_sh;
          w_rx_valid_nxt = 1'b1;
          w_state_nxt    = r_last ? ST_HOLD : ST_NEXT;
        end else begin
          w_shreg_nxt   = r_shreg << 1;
          w_mosi_nxt    = r_shreg[DATA_W-2];
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          w_state_nxt   = ST_LOW;
        end
      end
      ST_HOLD: if (w_tick) begin
        w_ssel_nxt  = SPI_SSEL_IDLE;
        w_mosi_nxt  = 1'b0;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: if (w_tick) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_last     <= 1'b0;
      r_sck      <= SPI_CPOL;
      r_mosi     <= 1'b0;
      r_ssel     <= SPI_SSEL_IDLE;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_last     <= w_last_nxt;
      r_sck      <= w_sck_nxt;
      r_mosi     <= w_mosi_nxt;
      r_ssel     <= w_ssel_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

  assign SCK      = r_sck;
  assign MOSI     = r_mosi;
  assign SSEL     = r_ssel;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: one instance at CLK_DIV=2, one at CLK_DIV=1, selected by sel;
// a pin monitor records SCK-rise samples and a word-level model predicts them.
module tb_spi_master_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic       sel = 1'b0, miso_one = 1'b0;

  logic [7:0] rx_data0, rx_data1;
  logic tx_ready0, rx_valid0, busy0, sck0, mosi0, ssel0, miso0;
  logic tx_ready1, rx_valid1, busy1, sck1, mosi1, ssel1, miso1;

  assign miso0 = miso_one ? 1'b1 : mosi0;
  assign miso1 = miso_one ? 1'b1 : mosi1;

  spi_master_tx #(.CLK_DIV(2), .DATA_W(8)) u_dut (
    .clk(clk), .res_n(res_n), .tx_data(tx_data), .tx_valid(tx_valid && !sel),
    .tx_last(tx_last), .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .busy(busy0), .SCK(sck0), .MOSI(mosi0), .MISO(miso0), .SSEL(ssel0));

  spi_master_tx #(.CLK_DIV(1), .DATA_W(8)) u_dut1 (
    .clk(clk), .res_n(res_n), .tx_data(tx_data), .tx_valid(tx_valid && sel),
    .tx_last(tx_last), .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .busy(busy1), .SCK(sck1), .MOSI(mosi1), .MISO(miso1), .SSEL(ssel1));

  wire       w_sck   = sel ? sck1 : sck0;
  wire       w_mosi  = sel ? mosi1 : mosi0;
  wire       w_miso  = sel ? miso1 : miso0;
  wire       w_ssel  = sel ? ssel1 : ssel0;
  wire       w_rdy   = sel ? tx_ready1 : tx_ready0;
  wire       w_rxv   = sel ? rx_valid1 : rx_valid0;
  wire       w_busy  = sel ? busy1 : busy0;
  wire [7:0] w_rxd   = sel ? rx_data1 : rx_data0;

  int total = 0, bad = 0;

  // Pin monitor, sampled on the falling edge away from the active edge.
  bit         mosi_q[$], miso_q[$];
  logic [7:0] rx_q[$];
  int         rise_t[$];
  int         ssel_low, ssel_rise, nrdy, viol, cyc;
  logic       p_sck = 1'b0, p_mosi = 1'b0, p_ssel = 1'b1;

  always @(negedge clk) begin
    if (w_sck && !p_sck) begin
      mosi_q.push_back(w_mosi); miso_q.push_back(w_miso); rise_t.push_back(cyc);
    end
    if (w_sck && p_sck && (w_mosi !== p_mosi)) viol++;
    if (w_rxv) rx_q.push_back(w_rxd);
    if (!w_ssel) ssel_low++;
    if (w_ssel && !p_ssel) ssel_rise++;
    if (!w_rdy) nrdy++;
    p_sck = w_sck; p_mosi = w_mosi; p_ssel = w_ssel;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    mosi_q.delete(); miso_q.delete(); rx_q.delete(); rise_t.delete();
    ssel_low = 0; ssel_rise = 0; nrdy = 0; viol = 0;
  endtask

  // Word w of the frame as seen on MOSI at SCK rises, MSB first.
  function automatic logic [7:0] mosi_word(input int w);
    logic [7:0] r = '0;
    for (int b = 0; b < 8; b++)
      r = {r[6:0], (w*8+b < mosi_q.size()) ? mosi_q[w*8+b] : 1'b0};
    return r;
  endfunction

  task automatic send(input logic [7:0] d, input logic l, input bit hold);
    int n = 0;
    @(negedge clk);
    tx_data = d; tx_last = l;
    while (!w_rdy && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("send_timeout", 0, 1);
    tx_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (w_busy && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic first_rise(input string tag, input int exp);
    int k = 0;
    @(negedge clk);
    while (!w_sck && k < 50) begin k++; @(negedge clk); end
    chk(tag, k, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] words [3];
    int nw, gap, k, bad_gap, mn, mx;

    repeat (3) @(negedge clk);
    chk("rst_ssel", w_ssel, 1); chk("rst_sck", w_sck, 0); chk("rst_mosi", w_mosi, 0);
    chk("rst_rdy", w_rdy, 1);   chk("rst_rxv", w_rxv, 0); chk("rst_rxd", w_rxd, 0);
    chk("rst_busy", w_busy, 0);
    res_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, loopback, with tx_valid pushed while busy.
    mon_clear();
    send(8'hA5, 1'b1, 1'b0);
    tx_data = 8'h11; tx_valid = 1'b1;
    repeat (20) @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();
    chk("a5_rises", mosi_q.size(), 8);
    chk("a5_mosi", mosi_word(0), 8'hA5);
    chk("a5_nrx", rx_q.size(), 1);
    chk("a5_rx", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA5);
    chk("a5_ssel_low", ssel_low, 17*2);
    chk("a5_notready", nrdy, 18*2);
    chk("a5_rdy_end", w_rdy, 1);
    chk("a5_viol", viol, 0);

    // Back-to-back burst with tx_valid held.
    mon_clear();
    send(8'h3C, 1'b0, 1'b1);
    send(8'hC3, 1'b1, 1'b0);
    wait_idle();
    chk("burst_rises", mosi_q.size(), 16);
    chk("burst_ssel_rise", ssel_rise, 1);
    chk("burst_nrx", rx_q.size(), 2);
    chk("burst_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h3C);
    chk("burst_rx1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'hC3);
    chk("burst_mosi1", mosi_word(1), 8'hC3);

    // Burst with a 10-cycle gap between words.
    mon_clear();
    send(8'h5A, 1'b0, 1'b0);
    first_rise("setup_len", 2);
    k = 0;
    while (!w_rdy && k < 200) begin @(negedge clk); k++; end
    bad_gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (w_ssel !== 1'b0 || w_sck !== 1'b0 || w_busy !== 1'b1 || w_rdy !== 1'b1) bad_gap++;
    end
    chk("gap_hold", bad_gap, 0);
    send(8'h96, 1'b1, 1'b0);
    first_rise("resume_low", 2);
    wait_idle();
    chk("gap_rises", mosi_q.size(), 16);
    chk("gap_ssel_rise", ssel_rise, 1);
    chk("gap_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h5A);
    chk("gap_rx1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h96);

    // MISO tied high, zero word, at both dividers.
    miso_one = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      repeat (2) @(negedge clk);
      mon_clear();
      send(8'h00, 1'b1, 1'b0);
      wait_idle();
      chk("z_rises", mosi_q.size(), 8);
      chk("z_mosi", mosi_word(0), 8'h00);
      chk("z_rx", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hFF);
      chk("z_ssel_low", ssel_low, 17*(2-s));
      mn = 1000; mx = 0;
      for (int i = 1; i < rise_t.size(); i++) begin
        if (rise_t[i]-rise_t[i-1] < mn) mn = rise_t[i]-rise_t[i-1];
        if (rise_t[i]-rise_t[i-1] > mx) mx = rise_t[i]-rise_t[i-1];
      end
      chk("z_period_min", mn, 2*(2-s));
      chk("z_period_max", mx, 2*(2-s));
    end
    miso_one = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a word.
    mon_clear();
    send(8'h5F, 1'b1, 1'b0);
    k = 0;
    while (mosi_q.size() < 3 && k < 200) begin @(negedge clk); k++; end
    res_n = 1'b0;
    #1;
    chk("mid_rst_ssel", w_ssel, 1); chk("mid_rst_sck", w_sck, 0);
    chk("mid_rst_rdy", w_rdy, 1);   chk("mid_rst_busy", w_busy, 0);
    chk("mid_rst_nrx", rx_q.size(), 0);
    @(negedge clk);
    res_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_clear();
    send(8'h81, 1'b1, 1'b0);
    wait_idle();
    chk("post_rst_mosi", mosi_word(0), 8'h81);
    chk("post_rst_rx", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h81);
    chk("post_rst_nrx", rx_q.size(), 1);

    // Randomized frames against the word-level model.
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom_range(0, 1));
      nw  = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) words[w] = 8'($urandom);
      repeat (2) @(negedge clk);
      mon_clear();
      for (int w = 0; w < nw; w++) begin
        gap = $urandom_range(0, 4);
        send(words[w], (w == nw-1), (gap == 0) && (w != nw-1));
        repeat (gap) @(negedge clk);
      end
      wait_idle();
      chk("rnd_rises", mosi_q.size(), nw*8);
      chk("rnd_nrx", rx_q.size(), nw);
      chk("rnd_ssel_rise", ssel_rise, 1);
      chk("rnd_viol", viol, 0);
      for (int w = 0; w < nw; w++) begin
        chk("rnd_mosi", mosi_word(w), words[w]);
        chk("rnd_rx", (rx_q.size() > w) ? rx_q[w] : 8'hxx, words[w]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
